arduino_pinmux: RTL and testbench

Second-generation Arduino header configuration block. It sits on the HPS lightweight Avalon-MM bus and drives the per-pin function select for the header muxes. Each pin carries a multi-bit mode field, written first to a shadow register. A commit sequencer then validates every shadow entry against a per-pin capability mask and applies all pins in a single cycle, or rejects the whole set and reports the first illegal pin.

---
 rtl/arduino_pinmux_pkg.sv | 35 +++
 rtl/arduino_pinmux_seq.sv | 74 +++++++
 rtl/arduino_pinmux.sv | 149 ++++++++++++++
 tb/tb_arduino_pinmux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arduino_pinmux_pkg.sv
// Shared constants for the Arduino header pin mux: mode encodings, register map,
// STATUS field positions and the commit sequencer state type.
package arduino_pinmux_pkg;

  localparam int MODE_GPIO = 0;
  localparam int MODE_I2C  = 1;
  localparam int MODE_SPI  = 2;
  localparam int MODE_UART = 3;
  localparam int MODE_PWM  = 4;
  localparam int MODE_LAST = 4;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_IRQ_EN = 2;
  localparam int PIN_BASE   = 4;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_REVERT = 1;

  localparam int ST_BUSY     = 0;
  localparam int ST_ERR      = 1;
  localparam int ST_FAIL_LSB = 8;
  localparam int ST_FAIL_W   = 6;

  // PIN registers return the active mode in the upper half-word
  localparam int ACTIVE_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_APPLY,
    S_REJECT
  } seq_state_e;

endpackage

// File: rtl/arduino_pinmux_seq.sv
// Commit sequencer: walks the shadow entries one per cycle, then either applies
// all pins at once or rejects the set and reports the first illegal index.
//
// state    | meaning
// S_IDLE   | waiting for COMMIT; REVERT honoured here only
// S_CHECK  | validating shadow[idx] against mode range and capability mask
// S_APPLY  | copy every shadow entry into the active set this cycle
// S_REJECT | latch ERR and FAIL_IDX, active set left untouched
module arduino_pinmux_seq
  import arduino_pinmux_pkg::*;
#(
  parameter int NUM_PINS   = 16,
  parameter int MODE_WIDTH = 3,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    revert,
  input  logic [MODE_WIDTH-1:0]   sel_mode,
  input  logic [2**MODE_WIDTH-1:0] sel_caps,
  output logic [IDX_W-1:0]        idx,
  output logic                    busy,
  output logic                    apply,
  output logic                    reject,
  output logic                    revert_go,
  output logic [ST_FAIL_W-1:0]    fail_idx
);

  seq_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             legal;

  assign legal = sel_caps[sel_mode] && (int'(sel_mode) <= MODE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CHECK;
          idx_nxt   = '0;
        end
      end
      S_CHECK: begin
        if (!legal)                             state_nxt = S_REJECT;
        else if (idx == IDX_W'(NUM_PINS - 1))   state_nxt = S_APPLY;
        else                                    idx_nxt   = idx + 1'b1;
      end
      S_APPLY:  state_nxt = S_IDLE;
      S_REJECT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // COMMIT takes priority when both bits arrive in one CTRL write
  assign revert_go = revert && !start && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign apply     = (state == S_APPLY);
  assign reject    = (state == S_REJECT);
  assign fail_idx  = ST_FAIL_W'(idx);

endmodule

// File: rtl/arduino_pinmux.sv
// Arduino header pin mux: Avalon-MM register file with shadow/active mode sets.
// Define ARDUINO_PINMUX_IRQ_EN to add the IRQ_EN register and the irq output.
module arduino_pinmux
  import arduino_pinmux_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_PINS   = 16,
  parameter int MODE_WIDTH = 3,
  parameter logic [NUM_PINS*(2**MODE_WIDTH)-1:0] PIN_CAPS = '1,
  parameter int ADDR_WIDTH = $clog2(4 + NUM_PINS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           write,
  input  logic [REG_WIDTH-1:0]           writedata,
  input  logic                           read,
  output logic [REG_WIDTH-1:0]           readdata,
  output logic                           readdatavalid,
  output logic                           waitrequest,
  output logic [NUM_PINS*MODE_WIDTH-1:0] pin_mode
`ifdef ARDUINO_PINMUX_IRQ_EN
  ,
  output logic                           irq
`endif
);

  localparam int CAPS_W = 2**MODE_WIDTH;
  localparam int IDX_W  = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;

  logic [MODE_WIDTH-1:0] shadow [NUM_PINS];
  logic [MODE_WIDTH-1:0] active [NUM_PINS];
  logic                  err;
  logic [ST_FAIL_W-1:0]  fail_q;
  logic                  busy, apply, reject, revert_go;
  logic [IDX_W-1:0]      idx, pin_sel;
  logic [ST_FAIL_W-1:0]  fail_idx;
  logic                  is_ctrl, is_status, is_pin;
  logic                  wr_ok, ctrl_wr, status_wr, pin_wr;
  logic [REG_WIDTH-1:0]  rd_mux;
  logic                  unused_wdata;

  assign is_ctrl   = (int'(addr) == REG_CTRL);
  assign is_status = (int'(addr) == REG_STATUS);
  assign is_pin    = (int'(addr) >= PIN_BASE) && (int'(addr) < PIN_BASE + NUM_PINS);
  assign pin_sel   = IDX_W'(int'(addr) - PIN_BASE);

  // STATUS and IRQ_EN stay writable mid-commit so software can clear ERR
  assign waitrequest = write && busy && (is_ctrl || is_pin);
  assign wr_ok       = write && !waitrequest;
  assign ctrl_wr     = wr_ok && is_ctrl;
  assign status_wr   = wr_ok && is_status;
  assign pin_wr      = wr_ok && is_pin;

  assign unused_wdata = ^writedata[REG_WIDTH-1:MODE_WIDTH];

  arduino_pinmux_seq #(
    .NUM_PINS  (NUM_PINS),
    .MODE_WIDTH(MODE_WIDTH),
    .IDX_W     (IDX_W)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (ctrl_wr && writedata[CTRL_COMMIT]),
    .revert   (ctrl_wr && writedata[CTRL_REVERT]),
    .sel_mode (shadow[idx]),
    .sel_caps (PIN_CAPS[int'(idx)*CAPS_W +: CAPS_W]),
    .idx      (idx),
    .busy     (busy),
    .apply    (apply),
    .reject   (reject),
    .revert_go(revert_go),
    .fail_idx (fail_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PINS; p++) begin
        shadow[p] <= '0;
        active[p] <= '0;
      end
      err    <= 1'b0;
      fail_q <= '0;
    end else begin
      if (apply) begin
        for (int p = 0; p < NUM_PINS; p++) active[p] <= shadow[p];
      end
      if (revert_go) begin
        for (int p = 0; p < NUM_PINS; p++) shadow[p] <= active[p];
      end
      if (pin_wr) shadow[pin_sel] <= writedata[MODE_WIDTH-1:0];
      // A reject landing with a W1C keeps ERR set
      if (reject) begin
        err    <= 1'b1;
        fail_q <= fail_idx;
      end else if (status_wr && writedata[ST_ERR]) begin
        err <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    assign pin_mode[p*MODE_WIDTH +: MODE_WIDTH] = active[p];
  end

`ifdef ARDUINO_PINMUX_IRQ_EN
  logic is_irq_en, irq_en;
  assign is_irq_en = (int'(addr) == REG_IRQ_EN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && is_irq_en) irq_en <= writedata[0];
      irq <= err && irq_en;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (is_status) begin
      rd_mux[ST_BUSY]                  = busy;
      rd_mux[ST_ERR]                   = err;
      rd_mux[ST_FAIL_LSB +: ST_FAIL_W] = fail_q;
    end
`ifdef ARDUINO_PINMUX_IRQ_EN
    else if (is_irq_en) begin
      rd_mux[0] = irq_en;
    end
`endif
    else if (is_pin) begin
      rd_mux[MODE_WIDTH-1:0]           = shadow[pin_sel];
      rd_mux[ACTIVE_LSB +: MODE_WIDTH] = active[pin_sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdata      <= read ? rd_mux : '0;
      readdatavalid <= read;
    end
  end

endmodule

// File: tb/tb_arduino_pinmux.sv
// Directed bench for arduino_pinmux: reset, legal/illegal commits, capability mask,
// write stall, revert and asynchronous reset mid-commit.
module tb_arduino_pinmux;

  localparam int NP = 16;
  localparam int MW = 3;
  localparam int AW = 5;
  // pin 2 may not use mode 1 (I2C)
  localparam logic [NP*8-1:0] CAPS = ~(128'(1) << 17);

  localparam logic [47:0] PM_A = 48'h8000_0000_0801;  // pin0=1, pin3=4, pin15=4
  localparam logic [47:0] PM_B = 48'h8000_0001_8801;  // PM_A plus pin5=3

  logic          clk, rst;
  logic [AW-1:0] addr;
  logic          write, read;
  logic [31:0]   writedata, readdata;
  logic          readdatavalid, waitrequest;
  logic [NP*MW-1:0] pin_mode;
`ifdef ARDUINO_PINMUX_IRQ_EN
  logic          irq;
`endif

  int compared   = 0;
  int mismatched = 0;

  arduino_pinmux #(
    .REG_WIDTH (32),
    .NUM_PINS  (NP),
    .MODE_WIDTH(MW),
    .PIN_CAPS  (CAPS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write        (write),
    .writedata    (writedata),
    .read         (read),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .waitrequest  (waitrequest),
    .pin_mode     (pin_mode)
`ifdef ARDUINO_PINMUX_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bus_write(input int a, input logic [31:0] d, output int stalls);
    @(negedge clk);
    addr = AW'(a); writedata = d; write = 1'b1; stalls = 0;
    #1;
    while (waitrequest && stalls < 100) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 100) begin
      compared++; mismatched++;
      $display("FAIL write_timeout: addr %0d still stalled after %0d cycles, required release", a, stalls);
    end
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d, output logic v);
    @(negedge clk);
    addr = AW'(a); read = 1'b1;
    @(posedge clk);
    #1;
    d = readdata; v = readdatavalid;
    read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v; int st;
    #1;
    compared++; if (pin_mode !== '0) begin mismatched++; $display("FAIL rst_pin_mode: got %h required 0", pin_mode); end
    compared++; if (readdata !== 32'h0) begin mismatched++; $display("FAIL rst_readdata: got %h required 0", readdata); end
    compared++; if (readdatavalid !== 1'b0) begin mismatched++; $display("FAIL rst_rdv: got %b required 0", readdatavalid); end
    compared++; if (waitrequest !== 1'b0) begin mismatched++; $display("FAIL rst_waitreq: got %b required 0", waitrequest); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    bus_read(1, d, v);
    compared++; if (v !== 1'b1) begin mismatched++; $display("FAIL status_rdv: got %b required 1", v); end
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL status_reset: got %h required 0", d); end
    @(posedge clk); #1;
    compared++; if (readdatavalid !== 1'b0) begin mismatched++; $display("FAIL rdv_drop: got %b required 0", readdatavalid); end
    bus_write(4 + 3, 32'h4, st);
    bus_read(4 + 3, d, v);
    compared++; if (d !== 32'h0000_0004) begin mismatched++; $display("FAIL pin3_shadow: got %h required 00000004", d); end
    bus_write(21, 32'h7, st);
    bus_read(21, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL out_of_range: got %h required 0", d); end
    bus_write(3, 32'hffff_ffff, st);
    bus_read(3, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL reserved3: got %h required 0", d); end
  endtask

  task automatic test_legal_commit();
    logic [31:0] d; logic v; int st;
    bus_write(4 + 0, 32'h1, st);
    bus_write(4 + 15, 32'h4, st);
    bus_write(0, 32'h1, st);
    addr = AW'(1); read = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      compared++;
      if (pin_mode !== ((k >= 17) ? PM_A : 48'h0)) begin
        mismatched++; $display("FAIL commit_pin_mode cycle %0d: got %h required %h", k, pin_mode, (k >= 17) ? PM_A : 48'h0);
      end
      compared++;
      if (readdata !== ((k <= 17) ? 32'h1 : 32'h0)) begin
        mismatched++; $display("FAIL commit_busy cycle %0d: got %h required %h", k, readdata, (k <= 17) ? 32'h1 : 32'h0);
      end
    end
    read = 1'b0;
    bus_read(4 + 15, d, v);
    compared++; if (d !== 32'h0004_0004) begin mismatched++; $display("FAIL pin15_readback: got %h required 00040004", d); end
    bus_read(0, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL ctrl_read: got %h required 0", d); end
  endtask

  task automatic test_illegal_mode();
    logic [31:0] d; logic v; int st;
    bus_write(4 + 7, 32'h6, st);
    bus_write(0, 32'h1, st);
    addr = AW'(1); read = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      compared++;
      if (pin_mode !== PM_A) begin mismatched++; $display("FAIL reject_pin_mode cycle %0d: got %h required %h", k, pin_mode, PM_A); end
      compared++;
      if (readdata !== ((k <= 9) ? 32'h1 : 32'h702)) begin
        mismatched++; $display("FAIL reject_status cycle %0d: got %h required %h", k, readdata, (k <= 9) ? 32'h1 : 32'h702);
      end
    end
    read = 1'b0;
    bus_write(1, 32'h2, st);
    bus_read(1, d, v);
    compared++; if (d[1] !== 1'b0) begin mismatched++; $display("FAIL err_w1c: got %b required 0", d[1]); end
    bus_write(4 + 7, 32'h0, st);
  endtask

  task automatic test_caps();
    logic [31:0] d; logic v; int st;
`ifdef ARDUINO_PINMUX_IRQ_EN
    bus_write(2, 32'h1, st);
`endif
    bus_write(4 + 2, 32'h1, st);
    bus_write(0, 32'h1, st);
    // W1C timed to hit the same edge as the reject
    repeat (3) @(posedge clk);
    #1;
    addr = AW'(1); writedata = 32'h2; write = 1'b1;
    #1;
    compared++; if (waitrequest !== 1'b0) begin mismatched++; $display("FAIL status_no_stall: got %b required 0", waitrequest); end
    @(posedge clk); #1 write = 1'b0;
`ifdef ARDUINO_PINMUX_IRQ_EN
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL irq_early: got %b required 0", irq); end
`endif
    bus_read(1, d, v);
    compared++; if (d !== 32'h0202) begin mismatched++; $display("FAIL caps_status: got %h required 00000202", d); end
    compared++; if (pin_mode !== PM_A) begin mismatched++; $display("FAIL caps_pin_mode: got %h required %h", pin_mode, PM_A); end
`ifdef ARDUINO_PINMUX_IRQ_EN
    compared++; if (irq !== 1'b1) begin mismatched++; $display("FAIL irq_set: got %b required 1", irq); end
    bus_read(2, d, v);
    compared++; if (d !== 32'h1) begin mismatched++; $display("FAIL irq_en_read: got %h required 1", d); end
`else
    bus_write(2, 32'h1, st);
    bus_read(2, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL addr2_reserved: got %h required 0", d); end
`endif
    bus_write(1, 32'h2, st);
    bus_read(1, d, v);
    compared++; if (d[1] !== 1'b0) begin mismatched++; $display("FAIL caps_w1c: got %b required 0", d[1]); end
`ifdef ARDUINO_PINMUX_IRQ_EN
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL irq_clear: got %b required 0", irq); end
`endif
    bus_write(4 + 2, 32'h0, st);
  endtask

  task automatic test_stall_revert();
    logic [31:0] d; logic v; int st;
    bus_write(0, 32'h1, st);
    bus_write(4 + 5, 32'h2, st);
    compared++; if (st !== NP + 1) begin mismatched++; $display("FAIL stall_cycles: got %0d required %0d", st, NP + 1); end
    bus_read(4 + 5, d, v);
    compared++; if (d !== 32'h0000_0002) begin mismatched++; $display("FAIL stalled_write: got %h required 00000002", d); end
    bus_write(0, 32'h2, st);
    bus_read(4 + 5, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL revert: got %h required 0", d); end
    compared++; if (pin_mode !== PM_A) begin mismatched++; $display("FAIL revert_pin_mode: got %h required %h", pin_mode, PM_A); end
    bus_write(4 + 5, 32'h3, st);
    bus_write(0, 32'h3, st);
    repeat (20) @(posedge clk);
    bus_read(4 + 5, d, v);
    compared++; if (d !== 32'h0003_0003) begin mismatched++; $display("FAIL commit_beats_revert: got %h required 00030003", d); end
    compared++; if (pin_mode !== PM_B) begin mismatched++; $display("FAIL commit_pm_b: got %h required %h", pin_mode, PM_B); end
  endtask

  task automatic test_reset_mid_commit();
    logic [31:0] d; logic v; int st;
    bus_write(4 + 1, 32'h2, st);
    bus_write(0, 32'h1, st);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    compared++; if (pin_mode !== '0) begin mismatched++; $display("FAIL midrst_pin_mode: got %h required 0", pin_mode); end
    @(negedge clk); rst = 1'b1;
    bus_read(1, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL midrst_status: got %h required 0", d); end
    bus_read(4 + 1, d, v);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL midrst_pin1: got %h required 0", d); end
    repeat (20) @(posedge clk);
    #1;
    compared++; if (pin_mode !== '0) begin mismatched++; $display("FAIL midrst_pin_mode_late: got %h required 0", pin_mode); end
  endtask

  initial begin
    rst = 1'b0; addr = '0; write = 1'b0; read = 1'b0; writedata = '0;
    test_reset();
    test_legal_commit();
    test_illegal_mode();
    test_caps();
    test_stall_revert();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
